// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regs
// Purpose  : I2C target responder exposing a 16-bit-addressed byte register
//            bank. Framing: 7-bit device address, 16-bit register pointer
//            (MSB first), then data bytes. SDA is open-drain through an
//            out/tristate pair. SCL is input only; there is no clock stretching.
// Ports    : clock      - system clock, at least 10x the SCL frequency
//            reset      - asynchronous, active-low reset
//            SCL_in     - raw SCL from the pad
//            SDA_in     - raw SDA from the pad
//            SDA_out    - open-drain data value, always 0
//            SDA_t      - pad tristate: 1 = release, 0 = drive low
//            reg_addr   - register pointer presented to the bank
//            reg_wdata  - write data, valid while reg_we is high
//            reg_we     - one-cycle write strobe
//            reg_re     - one-cycle read strobe
//            reg_rdata  - read data, returned by the bank the cycle after reg_re
//            busy       - high from a matched address byte until STOP or START
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_regs #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h29
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        SCL_in,
    input  logic        SDA_in,
    output logic        SDA_out,
    output logic        SDA_t,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADDR       = 4'd1,
        ADDR_ACK   = 4'd2,
        PTR_HI     = 4'd3,
        PTR_HI_ACK = 4'd4,
        PTR_LO     = 4'd5,
        PTR_LO_ACK = 4'd6,
        WR_DATA    = 4'd7,
        WR_ACK     = 4'd8,
        RD_DATA    = 4'd9,
        RD_ACK     = 4'd10,
        WAIT_STOP  = 4'd11
    } state_t;

    state_t      state;
    logic [2:0]  scl_sync;      // [0],[1] synchroniser stages, [2] previous synced value
    logic [2:0]  sda_sync;
    logic [7:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [3:0]  bit_cnt;       // bits received, or bits driven while in RD_DATA
    logic        rw;
    logic        rd_pending;    // bank data is valid on reg_rdata this cycle

    logic        scl;
    logic        scl_q;
    logic        sda;
    logic        sda_q;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_cond;
    logic        stop_cond;
    logic [7:0]  byte_in;

    assign SDA_out    = 1'b0;
    assign scl        = scl_sync[1];
    assign scl_q      = scl_sync[2];
    assign sda        = sda_sync[1];
    assign sda_q      = sda_sync[2];
    assign scl_rise   = scl & ~scl_q;
    assign scl_fall   = ~scl & scl_q;
    assign start_cond = scl & scl_q & sda_q & ~sda;
    assign stop_cond  = scl & scl_q & ~sda_q & sda;
    assign byte_in    = {rx_shift[6:0], sda};

    // Synchronisers reset to the idle-high bus level so that leaving reset
    // never looks like an edge or a bus condition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], SCL_in};
            sda_sync <= {sda_sync[1:0], SDA_in};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            SDA_t      <= 1'b1;
            reg_addr   <= 16'h0000;
            reg_wdata  <= 8'h00;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
            rx_shift   <= 8'h00;
            tx_shift   <= 8'h00;
            bit_cnt    <= 4'd0;
            rw         <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            rd_pending <= reg_re;

            if (rd_pending) begin
                tx_shift <= reg_rdata;
            end

            // Post-increment lands the cycle after the write strobe, so the
            // bank sees the strobe at the pre-increment address.
            if (reg_we) begin
                reg_addr <= reg_addr + 16'd1;
            end

            if (stop_cond) begin
                state   <= IDLE;
                SDA_t   <= 1'b1;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start_cond) begin
                state   <= ADDR;
                SDA_t   <= 1'b1;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    IDLE, WAIT_STOP: begin
                        SDA_t <= 1'b1;
                    end

                    ADDR, PTR_HI, PTR_LO, WR_DATA: begin
                        if (scl_rise) begin
                            rx_shift <= byte_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                case (state)
                                    ADDR: begin
                                        if (byte_in[7:1] == SLAVE_ADDRESS) begin
                                            busy  <= 1'b1;
                                            rw    <= byte_in[0];
                                            state <= ADDR_ACK;
                                            if (byte_in[0]) begin
                                                reg_re <= 1'b1;
                                            end
                                        end else begin
                                            state <= WAIT_STOP;
                                        end
                                    end
                                    PTR_HI: begin
                                        reg_addr[15:8] <= byte_in;
                                        state          <= PTR_HI_ACK;
                                    end
                                    PTR_LO: begin
                                        reg_addr[7:0] <= byte_in;
                                        state         <= PTR_LO_ACK;
                                    end
                                    default: begin
                                        reg_wdata <= byte_in;
                                        reg_we    <= 1'b1;
                                        state     <= WR_ACK;
                                    end
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // Every ACK state is entered on the 8th SCL rise with SDA
                    // released: the first fall pulls SDA low, the second fall
                    // ends the ACK slot.
                    ADDR_ACK, PTR_HI_ACK, PTR_LO_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            if (SDA_t) begin
                                SDA_t <= 1'b0;
                            end else if (state == ADDR_ACK && rw) begin
                                // The fall ending the ACK also presents data bit 7.
                                SDA_t    <= tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                bit_cnt  <= 4'd1;
                                state    <= RD_DATA;
                            end else begin
                                SDA_t   <= 1'b1;
                                bit_cnt <= 4'd0;
                                case (state)
                                    ADDR_ACK:   state <= PTR_HI;
                                    PTR_HI_ACK: state <= PTR_LO;
                                    default:    state <= WR_DATA;
                                endcase
                            end
                        end
                    end

                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                SDA_t <= 1'b1;
                                state <= RD_ACK;
                            end else begin
                                SDA_t    <= tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda) begin
                                // Next byte is fetched now; it is loaded well before
                                // the fall that presents its first bit.
                                reg_addr <= reg_addr + 16'd1;
                                reg_re   <= 1'b1;
                                bit_cnt  <= 4'd0;
                                state    <= RD_DATA;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                        SDA_t <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_regs
// Purpose  : Self-checking bench for i2c_target_regs. A bit-level I2C
//            controller drives the bus; a byte-array register bank answers
//            the strobes; a pointer/memory model predicts acks, strobes,
//            read data and the final pointer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regs;

    localparam logic [6:0] DEV = 7'h29;
    localparam int         Q   = 4;     // clocks per quarter SCL period

    logic        clock = 1'b0;
    logic        reset;
    logic        m_scl;
    logic        m_sda;
    logic        sda_bus;
    logic        SDA_out;
    logic        SDA_t;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  bank_rdata;
    logic        busy;

    always #5 clock = ~clock;

    assign sda_bus = m_sda & (SDA_t ? 1'b1 : SDA_out);

    i2c_target_regs #(.SLAVE_ADDRESS(DEV)) dut (
        .clock     (clock),
        .reset     (reset),
        .SCL_in    (m_scl),
        .SDA_in    (sda_bus),
        .SDA_out   (SDA_out),
        .SDA_t     (SDA_t),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (bank_rdata),
        .busy      (busy)
    );

    // ---------------- register bank attached to the DUT ----------------
    logic [7:0] bank    [0:65535];
    bit         bank_wr [0:65535];

    function automatic logic [7:0] bank_init(input logic [15:0] a);
        if (a == 16'hA6A6) return 8'hC3;
        if (a == 16'hA6A7) return 8'h3C;
        return a[15:8] ^ a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clock) begin
        if (reg_we) begin
            bank[reg_addr]    <= reg_wdata;
            bank_wr[reg_addr] <= 1'b1;
        end
        if (reg_re) begin
            bank_rdata <= bank_wr[reg_addr] ? bank[reg_addr] : bank_init(reg_addr);
        end
    end

    // ---------------- strobe monitor (append-only) ----------------
    logic [23:0] we_q [$];
    logic [15:0] re_q [$];
    int          overlap_cnt = 0;
    int          low_cnt     = 0;

    always @(negedge clock) begin
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_re) re_q.push_back(reg_addr);
        if (reg_we && reg_re) overlap_cnt <= overlap_cnt + 1;
        if (!SDA_t) low_cnt <= low_cnt + 1;
    end

    // ---------------- reference model ----------------
    logic [7:0]  model_mem [0:65535];
    bit          model_wr  [0:65535];
    logic [15:0] model_ptr;

    function automatic logic [7:0] model_read(input logic [15:0] a);
        return model_wr[a] ? model_mem[a] : bank_init(a);
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- bit-level controller ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_clk(2 * Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        b = sda_bus;  wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(x);
            b[i] = x;
        end
        send_bit(~ack);
    endtask

    // ---------------- transactions ----------------
    typedef struct {
        bit              is_read;
        bit              set_ptr;   // reads: pointer write + repeated START first
        logic [6:0]      dev;
        logic [15:0]     ptr;
        int              n;
        logic [3:0][7:0] wdata;
        logic [3:0][7:0] rdata;     // expected read bytes (table rows)
        logic [15:0]     exp_addr;  // expected pointer after STOP (table rows)
    } txn_t;

    task automatic run_txn(input txn_t t, input bit tbl);
        logic        ack;
        logic        match;
        logic [7:0]  rb;
        logic [23:0] exp_we [$];
        logic [15:0] exp_re [$];
        int          we_base;
        int          re_base;
        int          ov_base;
        int          low_base;

        we_base  = we_q.size();
        re_base  = re_q.size();
        ov_base  = overlap_cnt;
        low_base = low_cnt;
        match    = (t.dev == DEV);

        bus_start();
        if (!t.is_read || t.set_ptr) begin
            write_byte({t.dev, 1'b0}, ack);
            check("addr_ack", 32'(ack), 32'(match));
            check("busy_after_addr", 32'(busy), 32'(match));
            write_byte(t.ptr[15:8], ack);
            check("ptr_hi_ack", 32'(ack), 32'(match));
            write_byte(t.ptr[7:0], ack);
            check("ptr_lo_ack", 32'(ack), 32'(match));
            if (match) model_ptr = t.ptr;
        end

        if (!t.is_read) begin
            for (int i = 0; i < t.n; i++) begin
                write_byte(t.wdata[i], ack);
                check("data_ack", 32'(ack), 32'(match));
                if (match) begin
                    exp_we.push_back({model_ptr, t.wdata[i]});
                    model_mem[model_ptr] = t.wdata[i];
                    model_wr[model_ptr]  = 1'b1;
                    model_ptr            = model_ptr + 16'd1;
                end
            end
        end else begin
            if (t.set_ptr) begin
                bus_start();
                check("busy_after_sr", 32'(busy), 32'd0);
            end
            write_byte({t.dev, 1'b1}, ack);
            check("rd_addr_ack", 32'(ack), 32'(match));
            if (match) begin
                for (int i = 0; i < t.n; i++) begin
                    exp_re.push_back(model_ptr);
                    read_byte(i != t.n - 1, rb);
                    check("rd_data_model", 32'(rb), 32'(model_read(model_ptr)));
                    if (tbl) check("rd_data_table", 32'(rb), 32'(t.rdata[i]));
                    if (i != t.n - 1) model_ptr = model_ptr + 16'd1;
                end
                check("sda_released_after_nack", 32'(SDA_t), 32'd1);
            end
        end
        bus_stop();

        check("busy_after_stop", 32'(busy), 32'd0);
        check("ptr_model", 32'(reg_addr), 32'(model_ptr));
        if (tbl) check("ptr_table", 32'(reg_addr), 32'(t.exp_addr));
        check("we_count", 32'(we_q.size() - we_base), 32'(exp_we.size()));
        for (int i = 0; i < exp_we.size() && we_base + i < we_q.size(); i++)
            check("we_event", 32'(we_q[we_base + i]), 32'(exp_we[i]));
        check("re_count", 32'(re_q.size() - re_base), 32'(exp_re.size()));
        for (int i = 0; i < exp_re.size() && re_base + i < re_q.size(); i++)
            check("re_event", 32'(re_q[re_base + i]), 32'(exp_re[i]));
        check("we_re_overlap", 32'(overlap_cnt - ov_base), 32'd0);
        if (!match) check("no_drive_on_mismatch", 32'(low_cnt - low_base), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    txn_t tbl [7];
    txn_t t;

    initial begin
        logic ack;

        tbl[0] = '{1'b1, 1'b1, DEV,   16'hA6A6, 2, 32'h0,    32'h3CC3, 16'hA6A7};
        tbl[1] = '{1'b0, 1'b1, DEV,   16'hA6A6, 1, 32'h5A,   32'h0,    16'hA6A7};
        tbl[2] = '{1'b0, 1'b1, 7'h30, 16'h0000, 0, 32'h0,    32'h0,    16'hA6A7};
        tbl[3] = '{1'b0, 1'b1, DEV,   16'hFFFF, 2, 32'h2211, 32'h0,    16'h0001};
        tbl[4] = '{1'b1, 1'b1, DEV,   16'hFFFF, 2, 32'h0,    32'h2211, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, DEV,   16'h0000, 1, 32'h0,    32'h22,   16'h0000};
        tbl[6] = '{1'b1, 1'b1, DEV,   16'hA6A6, 1, 32'h0,    32'h5A,   16'hA6A6};

        m_scl     = 1'b1;
        m_sda     = 1'b1;
        reset     = 1'b0;
        model_ptr = 16'h0000;
        wait_clk(3);
        check("rst_sda_t",     32'(SDA_t),     32'd1);
        check("rst_sda_out",   32'(SDA_out),   32'd0);
        check("rst_we",        32'(reg_we),    32'd0);
        check("rst_re",        32'(reg_re),    32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_reg_addr",  32'(reg_addr),  32'd0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        reset = 1'b1;
        wait_clk(4);

        for (int i = 0; i < 7; i++) run_txn(tbl[i], 1'b1);

        // Abort: STOP after 4 data bits -> no write, pointer kept.
        begin
            int we_base;
            we_base = we_q.size();
            bus_start();
            write_byte({DEV, 1'b0}, ack);
            write_byte(8'h12, ack);
            write_byte(8'h34, ack);
            send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
            bus_stop();
            model_ptr = 16'h1234;
            check("abort_no_we",  32'(we_q.size() - we_base), 32'd0);
            check("abort_ptr",    32'(reg_addr), 32'h1234);
            check("abort_busy",   32'(busy), 32'd0);
            t = '{1'b0, 1'b1, DEV, 16'h1234, 1, 32'h77, 32'h0, 16'h1235};
            run_txn(t, 1'b1);
        end

        // Reset while the target is driving the leading 0 of 0x5A at A6A6.
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'hA6, ack);
        write_byte(8'hA6, ack);
        bus_start();
        write_byte({DEV, 1'b1}, ack);
        check("rstrd_addr_ack", 32'(ack), 32'd1);
        wait_clk(1);
        check("rstrd_driving_0", 32'(SDA_t), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rstrd_sda_t", 32'(SDA_t),    32'd1);
        check("rstrd_busy",  32'(busy),     32'd0);
        check("rstrd_addr",  32'(reg_addr), 32'd0);
        m_sda = 1'b1; wait_clk(2);
        m_scl = 1'b1; wait_clk(2);
        reset = 1'b1;
        wait_clk(4);
        model_ptr = 16'h0000;

        // Randomised transactions against the model.
        for (int k = 0; k < 25; k++) begin
            t.is_read  = 1'($urandom_range(0, 1));
            t.set_ptr  = t.is_read ? 1'($urandom_range(0, 1)) : 1'b1;
            t.dev      = ($urandom_range(0, 7) == 0) ? (DEV ^ 7'($urandom_range(1, 127))) : DEV;
            t.ptr      = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 2)))
                                                      : 16'($urandom);
            t.n        = $urandom_range(1, 3);
            t.wdata    = 32'($urandom);
            t.rdata    = 32'h0;
            t.exp_addr = 16'h0000;
            run_txn(t, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
I2C target (slave) responder that exposes a 16-bit-addressed byte register bank to an external I2C controller. It uses the same device/register framing as the ToF sensor: 7-bit device address, 16-bit register pointer sent MSB first, then data bytes. It serves as the sensor-side model for closed-loop verification of the I2C controller, and as an FPGA-side register port. SDA is open-drain via an IOBUF-style out/tristate pair; SCL is input only (no clock stretching).

Parameters:
SLAVE_ADDRESS, 7'h29, 7-bit device address the block answers to.

Ports:
clock  in  1  system clock; must be ≥10× SCL frequency.
reset  in  1  asynchronous, active-low reset.
SCL_in  in  1  raw SCL from pad.
SDA_in  in  1  raw SDA from pad.
SDA_out  out  1  constant 0 (open-drain data value).
SDA_t  out  1  pad tristate: 1 = release (high-Z), 0 = drive low.
reg_addr  out  16  register pointer presented to the bank.
reg_wdata  out  8  write data; valid while reg_we = 1.
reg_we  out  1  one-cycle write strobe.
reg_re  out  1  one-cycle read strobe.
reg_rdata  in  8  read data; bank returns it the cycle after reg_re, and the block captures it then.
busy  out  1  high from matched address byte until STOP or repeated START.

Behaviour:
- Reset (reset = 0, async): SDA_t = 1, reg_we = reg_re = 0, busy = 0, reg_addr = 16'h0000, reg_wdata = 0, FSM = IDLE, shift and bit counters = 0.
- SCL_in and SDA_in pass through 2-flop synchronisers. Edge detects run on the synchronised values.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data is sampled on the SCL rising edge.
  - SDA_t changes only on the cycle after the SCL falling edge is detected.
- STOP in any state: go to IDLE, SDA_t = 1, busy = 0.
- START in any state (including repeated START): go to ADDR, bit counter = 0, SDA_t = 1.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_HI_ACK, PTR_LO, PTR_LO_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR: shift in 8 bits, MSB first.
  - On a match of bits [7:1] to SLAVE_ADDRESS: drive ACK (SDA_t = 0) from the 8th SCL fall to the 9th SCL fall, and set busy = 1.
  - R/W = 0: go to PTR_HI. R/W = 1: pulse reg_re with the current reg_addr at ACK entry, load the shift register, then go to RD_DATA.
  - Mismatch: no ACK, go to WAIT_STOP.
- PTR_HI / PTR_LO: receive the pointer high byte, then the low byte, each ACKed. reg_addr updates when each byte completes.
- WR_DATA: each received byte produces:
  - reg_wdata = byte and a one-cycle reg_we pulse at the current reg_addr, issued on the 8th-bit SCL rise plus the sync delay;
  - an ACK;
  - reg_addr += 1 after the strobe.
- RD_DATA:
  - Shift the byte out MSB first. SDA_t = 0 for a 0 bit, 1 for a 1 bit.
  - The first bit is driven on the SCL fall that ends the address ACK; each later bit on the next SCL fall.
  - After bit 8, release SDA and sample the controller's ACK on the 9th SCL rise.
- RD_ACK:
  - Controller ACK (SDA = 0): reg_addr += 1, pulse reg_re, load the new byte, return to RD_DATA.
  - Controller NACK: go to WAIT_STOP with SDA released.
- Pointer arithmetic is 16-bit modulo: 16'hFFFF + 1 = 16'h0000. The pointer persists across transactions until reset.
- WAIT_STOP: ignore all bits and keep SDA_t = 1 until STOP or START.
- A STOP or START mid-byte aborts the partial byte: no reg_we, and the pointer is unchanged.
- reg_we and reg_re are never asserted in the same cycle, and each is at most one pulse per byte.

Test Plan:
- Write: START, 0x52, 0xA6, 0xA6, 0x5A, STOP -> ACK on all 4 bytes; one reg_we with reg_addr = 16'hA6A6, reg_wdata = 8'h5A; busy falls at STOP.
- Combined read: START, 0x52, 0xA6, 0xA6, Sr, 0x53, read 2 bytes (ACK, then NACK), STOP; bank returns 0xC3 at A6A6 and 0x3C at A6A7 -> SDA carries 11000011 then 00111100; reg_re pulses at A6A6 and A6A7; SDA_t = 1 after NACK.
- Address mismatch: START, 0x60, 0x00, STOP -> SDA_t stays 1 throughout; no reg_we/reg_re; busy stays 0.
- Wrap: write pointer 0xFFFF, then data 0x11, 0x22 -> reg_we at FFFF (0x11), then at 0000 (0x22).
- Abort: STOP after 4 data bits of a write byte -> no reg_we; FSM returns to IDLE; the next transaction is ACKed normally.
- Reset mid-read (while driving a 0 bit) -> SDA_t = 1 and busy = 0 immediately; reg_addr = 0.
